sccb_responder: RTL and testbench
=================================

// Module: sccb_responder
// PURPOSE
//   SCCB/I2C target that emulates the OV7670 configuration port: the far end of the
//   cmos_scl/cmos_sda link driven by the camera-config master.
//   Used as the bench/loopback stand-in for the sensor. Its register file is visible
//   to the board through a debug read port and a write-event strobe (e.g. ledG).
//   Oversamples SCL/SDA in the clk domain. Drives SDA open-drain through sda_oe only.
// PARAMETERS
//   DEV_ADDR     7'h21  7-bit target address (0x42 write / 0x43 read)
//   SYNC_STAGES  2      synchroniser flops on scl_i/sda_i (>=2)
//   PID_VAL      8'h76  read-only value at sub-address 0x0A
//   VER_VAL      8'h73  read-only value at sub-address 0x0B
// PORTS
//   clk        in   1  system clock (clk_50), >= 20x SCL frequency
//   rst        in   1  synchronous reset, active-high
//   scl_i      in   1  SCL line level (async)
//   sda_i      in   1  SDA line level (async)
//   sda_oe     out  1  1 = pull SDA low, 0 = release
//   wr_strobe  out  1  1-cycle pulse per accepted data byte written to a RW register
//   wr_addr    out  8  sub-address of that write (valid with wr_strobe)
//   wr_data    out  8  data of that write (valid with wr_strobe)
//   busy       out  1  1 from START to STOP (addressed or not)
//   dbg_addr   in   8  debug read address
//   dbg_data   out  8  register contents at dbg_addr, 1-cycle registered latency
// BEHAVIOUR
//   Reset: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, dbg_data=0, FSM=IDLE,
//     sub pointer=0. The regfile is NOT cleared by rst; its power-up init is all 0x00.
//     Reset mid-transaction releases SDA at the next cycle and ignores the bus until
//     a new START.
//   Sync: scl/sda are sampled through SYNC_STAGES flops. Edge detects use the last two
//     synced samples. START = sda fall while scl high. STOP = sda rise while scl high.
//   Bits are sampled on synced SCL rise, MSB first. sda_oe changes only on the cycle of
//     a synced SCL fall detect.
//   FSM: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE.
//   IDLE -START-> DEV. DEV collects 8 bits with a 3-bit counter.
//   Address byte [7:1]!=DEV_ADDR -> IGNORE (no ACK, sda_oe stays 0) until STOP/START.
//   Match: sda_oe=1 for the 9th clock (fall after bit 8 to the next fall).
//     R/W=0 -> SUB. R/W=1 -> RDAT.
//   SUB: the byte loads the sub pointer, then ACK (SUB_ACK) -> WDAT.
//   WDAT: after 8th bit -> ACK, write regfile[ptr], pulse wr_strobe, ptr=ptr+1.
//     ptr wraps 0xFF->0x00. Further bytes repeat WDAT.
//     Writes to 0x0A/0x0B are ACKed but discarded, with no wr_strobe.
//   RDAT: byte = regfile[ptr] (PID_VAL/VER_VAL at 0x0A/0x0B), latched at the fall
//     ending the ACK. Drive sda_oe = ~bit on each fall for 8 bits, then release.
//     9th rise samples the master: SDA low (ACK) -> ptr+1 (wrap), next byte.
//     NACK -> IGNORE.
//   STOP in any state -> IDLE, sda_oe=0 in the same cycle as the detect, busy=0.
//   Repeated START in any state -> DEV, sda_oe=0, bit counter cleared, ptr kept.
//   Write then read uses ptr set by the prior write phase (OV7670 2-phase read).
//   Partial byte before STOP/START: discarded, no strobe, no ptr change.
//   dbg_data: registered read of regfile[dbg_addr]. A same-cycle write to dbg_addr
//     returns the old value; the new value appears one cycle later.
// TESTING
//   1. Write 0x42,0x12,0x80,STOP -> ACKs on all 3 bytes; wr_strobe once with
//      wr_addr=0x12, wr_data=0x80; dbg_addr=0x12 -> dbg_data=0x80 next cycle.
//   2. Write 0x42,0x0A,STOP; then 0x43 + read + NACK -> SDA bits = 0x76; sda_oe released
//      on the 9th clock; busy=0 after STOP.
//   3. Address 0x44 + 2 bytes -> sda_oe never 1, no wr_strobe, busy=1 until STOP.
//   4. Write 0x42,0xFE,0x11,0x22,0x33 -> regs FE=0x11, FF=0x22, 00=0x33; three strobes.
//   5. Assert rst during the 4th data bit of a write -> sda_oe=0 next cycle, no strobe,
//      regfile unchanged; the next full transaction succeeds.
//   6. Repeated START after the sub byte, then 0x43 read with ACK, ACK, NACK ->
//      3 bytes from ptr, ptr+1, ptr+2.

Source files
------------

// File: rtl/sccb_responder_if.sv
// SCCB bus seen by the responder: oversampled SCL/SDA levels in, open-drain SDA pull-down out.
interface sccb_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/sccb_responder.sv
// SCCB/I2C target emulating the OV7670 config port: 256-byte register file with
// auto-incrementing sub-address pointer, read-only PID/VER, debug read port.
module sccb_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h21,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  PID_VAL     = 8'h76,
  parameter logic [7:0]  VER_VAL     = 8'h73
) (
  input  logic              clk,
  input  logic              rst,
  sccb_responder_if.slave   bus,
  output logic              wr_strobe,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  input  logic [7:0]        dbg_addr,
  output logic [7:0]        dbg_data
);

  typedef enum logic [3:0] {
    StIdle, StDev, StDevAck, StSub, StSubAck, StWdat, StWdatAck, StRdat, StRdatAck, StIgnore
  } state_e;

  // Synchronisers are deliberately not reset so that reset never fabricates a bus edge.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_p, sda_p;

  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
    scl_p    <= scl_s;
    sda_p    <= sda_s;
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  logic [7:0] regfile [256] = '{default: 8'h00};

  state_e     state_q;
  logic [7:0] ptr_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] tx_q;
  logic       rw_q;
  logic       ack_on_q;   // inside the ACK clock (first fall seen)
  logic       mack_q;     // master ACKed the byte just sent
  logic       sda_oe_q;

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       ro_ptr;

  assign rx_byte = {shift_q, sda_s};
  assign ro_ptr  = (ptr_q == 8'h0A) || (ptr_q == 8'h0B);

  always_comb begin
    rd_byte = regfile[ptr_q];
    if (ptr_q == 8'h0A) begin
      rd_byte = PID_VAL;
    end else if (ptr_q == 8'h0B) begin
      rd_byte = VER_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      ack_on_q  <= 1'b0;
      mack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (start_det) begin
        state_q   <= StDev;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
        busy      <= 1'b1;
      end else begin
        case (state_q)
          StDev, StSub, StWdat: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_on_q <= 1'b0;
                if (state_q == StDev) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    rw_q    <= rx_byte[0];
                    state_q <= StDevAck;
                  end else begin
                    state_q <= StIgnore;
                  end
                end else if (state_q == StSub) begin
                  ptr_q   <= rx_byte;
                  state_q <= StSubAck;
                end else begin
                  // PID/VER writes are acknowledged but dropped; the pointer still advances.
                  if (!ro_ptr) begin
                    regfile[ptr_q] <= rx_byte;
                    wr_strobe      <= 1'b1;
                    wr_addr        <= ptr_q;
                    wr_data        <= rx_byte;
                  end
                  ptr_q   <= ptr_q + 8'd1;
                  state_q <= StWdatAck;
                end
              end
            end
          end
          StDevAck, StSubAck, StWdatAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                bit_cnt_q <= '0;
                if (state_q == StDevAck && rw_q) begin
                  tx_q     <= {rd_byte[6:0], 1'b0};
                  sda_oe_q <= ~rd_byte[7];
                  state_q  <= StRdat;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == StDevAck) ? StSub : StWdat;
                end
              end
            end
          end
          StRdat: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_on_q <= 1'b0;
                mack_q   <= 1'b0;
                state_q  <= StRdatAck;
              end
            end else if (scl_fall) begin
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
          end
          StRdatAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b0;
                ack_on_q <= 1'b1;
              end else if (mack_q) begin
                bit_cnt_q <= '0;
                tx_q      <= {rd_byte[6:0], 1'b0};
                sda_oe_q  <= ~rd_byte[7];
                state_q   <= StRdat;
              end
            end else if (scl_rise && ack_on_q && !mack_q) begin
              if (sda_s) begin
                state_q <= StIgnore;
              end else begin
                ptr_q  <= ptr_q + 8'd1;
                mack_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe = sda_oe_q;

  // Same-cycle write to dbg_addr returns the old contents by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= regfile[dbg_addr];
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master with open-drain SDA model,
// table-driven write transactions plus hand-written read/reset/wrap sequences.
module tb_sccb_responder;

  localparam int Q = 5;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  sccb_responder_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  sccb_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         strobe_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) begin
    if (!rst && wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= wr_addr;
      last_data  <= wr_data;
    end
    if (!rst && bus.sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic line, output logic oe);
    wait_n(Q);
    sda_m = b;
    wait_n(Q);
    scl_m = 1'b1;
    wait_n(Q);
    line = bus.sda_i;
    oe   = bus.sda_oe;
    wait_n(Q);
    scl_m = 1'b0;
  endtask

  task automatic send_start();
    sda_m = 1'b1;
    wait_n(Q);
    scl_m = 1'b1;
    wait_n(2 * Q);
    sda_m = 1'b0;
    wait_n(2 * Q);
    scl_m = 1'b0;
  endtask

  task automatic send_stop();
    wait_n(Q);
    sda_m = 1'b0;
    wait_n(Q);
    scl_m = 1'b1;
    wait_n(2 * Q);
    sda_m = 1'b1;
    wait_n(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic l, o;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], l, o);
    clk_bit(1'b1, l, o);
    ack = ~l;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b, output logic oe9);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, l, o);
      b[i] = l;
    end
    clk_bit(~mack, l, oe9);
  endtask

  task automatic dbg_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    wait_n(2);
    check(name, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [7:0] dat;
    logic       ack;
    logic       strb;
    logic [7:0] dbg_a;
    logic [7:0] dbg_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       a0, a1, a2, oe9;
    logic [7:0] rb;
    int         s0, o0;

    vecs[0] = '{dev: 8'h42, sub: 8'h12, dat: 8'h80, ack: 1'b1, strb: 1'b1, dbg_a: 8'h12, dbg_d: 8'h80};
    vecs[1] = '{dev: 8'h42, sub: 8'h0A, dat: 8'h55, ack: 1'b1, strb: 1'b0, dbg_a: 8'h0A, dbg_d: 8'h00};
    vecs[2] = '{dev: 8'h42, sub: 8'h0B, dat: 8'h66, ack: 1'b1, strb: 1'b0, dbg_a: 8'h0B, dbg_d: 8'h00};
    vecs[3] = '{dev: 8'h44, sub: 8'h12, dat: 8'h99, ack: 1'b0, strb: 1'b0, dbg_a: 8'h12, dbg_d: 8'h80};
    vecs[4] = '{dev: 8'h40, sub: 8'h21, dat: 8'h77, ack: 1'b0, strb: 1'b0, dbg_a: 8'h21, dbg_d: 8'h00};
    vecs[5] = '{dev: 8'h42, sub: 8'h7F, dat: 8'hC3, ack: 1'b1, strb: 1'b1, dbg_a: 8'h7F, dbg_d: 8'hC3};

    rst      = 1'b1;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    dbg_addr = 8'h00;
    wait_n(6);
    check("rst_sda_oe",   {31'h0, bus.sda_oe}, 32'h0);
    check("rst_strobe",   {31'h0, wr_strobe},  32'h0);
    check("rst_wr_addr",  {24'h0, wr_addr},    32'h0);
    check("rst_wr_data",  {24'h0, wr_data},    32'h0);
    check("rst_busy",     {31'h0, busy},       32'h0);
    check("rst_dbg_data", {24'h0, dbg_data},   32'h0);
    rst = 1'b0;
    wait_n(4);
    dbg_check("powerup_reg55", 8'h55, 8'h00);

    // Table-driven single-byte writes, including non-matching addresses.
    for (int k = 0; k < 6; k++) begin
      s0 = strobe_cnt;
      o0 = oe_cnt;
      send_start();
      write_byte(vecs[k].dev, a0);
      write_byte(vecs[k].sub, a1);
      write_byte(vecs[k].dat, a2);
      check($sformatf("v%0d_busy_mid", k), {31'h0, busy}, 32'h1);
      send_stop();
      wait_n(4);
      check($sformatf("v%0d_ack_dev", k), {31'h0, a0}, {31'h0, vecs[k].ack});
      check($sformatf("v%0d_ack_sub", k), {31'h0, a1}, {31'h0, vecs[k].ack});
      check($sformatf("v%0d_ack_dat", k), {31'h0, a2}, {31'h0, vecs[k].ack});
      check($sformatf("v%0d_busy_end", k), {31'h0, busy}, 32'h0);
      check($sformatf("v%0d_strobes", k), strobe_cnt - s0, {31'h0, vecs[k].strb});
      if (vecs[k].strb) begin
        check($sformatf("v%0d_wr_addr", k), {24'h0, last_addr}, {24'h0, vecs[k].sub});
        check($sformatf("v%0d_wr_data", k), {24'h0, last_data}, {24'h0, vecs[k].dat});
      end
      if (!vecs[k].ack) check($sformatf("v%0d_oe_never", k), oe_cnt - o0, 32'h0);
      dbg_check($sformatf("v%0d_dbg", k), vecs[k].dbg_a, vecs[k].dbg_d);
    end

    // Two-phase read of PID, then PID/VER with master ACK.
    send_start();
    write_byte(8'h42, a0);
    write_byte(8'h0A, a1);
    send_stop();
    send_start();
    write_byte(8'h43, a0);
    check("rd1_ack_dev", {31'h0, a0}, 32'h1);
    read_byte(1'b0, rb, oe9);
    check("rd1_pid", {24'h0, rb}, 32'h76);
    check("rd1_oe_9th", {31'h0, oe9}, 32'h0);
    send_stop();
    wait_n(4);
    check("rd1_busy_end", {31'h0, busy}, 32'h0);

    send_start();
    write_byte(8'h42, a0);
    write_byte(8'h0A, a1);
    send_stop();
    send_start();
    write_byte(8'h43, a0);
    read_byte(1'b1, rb, oe9);
    check("rd2_pid", {24'h0, rb}, 32'h76);
    read_byte(1'b0, rb, oe9);
    check("rd2_ver", {24'h0, rb}, 32'h73);
    send_stop();

    // Multi-byte write wrapping the pointer past 0xFF.
    s0 = strobe_cnt;
    send_start();
    write_byte(8'h42, a0);
    write_byte(8'hFE, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a2);
    write_byte(8'h33, a2);
    send_stop();
    wait_n(4);
    check("wrap_ack_last", {31'h0, a2}, 32'h1);
    check("wrap_strobes", strobe_cnt - s0, 32'd3);
    dbg_check("wrap_regFE", 8'hFE, 8'h11);
    dbg_check("wrap_regFF", 8'hFF, 8'h22);
    dbg_check("wrap_reg00", 8'h00, 8'h33);

    // Repeated START after the sub byte, then burst read across the wrap.
    send_start();
    write_byte(8'h42, a0);
    write_byte(8'hFE, a1);
    send_start();
    write_byte(8'h43, a0);
    check("rs_ack_dev", {31'h0, a0}, 32'h1);
    read_byte(1'b1, rb, oe9);
    check("rs_byte0", {24'h0, rb}, 32'h11);
    read_byte(1'b1, rb, oe9);
    check("rs_byte1", {24'h0, rb}, 32'h22);
    read_byte(1'b0, rb, oe9);
    check("rs_byte2", {24'h0, rb}, 32'h33);
    check("rs_oe_9th", {31'h0, oe9}, 32'h0);
    send_stop();

    // Reset during the 4th data bit of a write.
    s0 = strobe_cnt;
    send_start();
    write_byte(8'h42, a0);
    write_byte(8'h30, a1);
    for (int i = 7; i >= 5; i--) clk_bit(1'b1, a2, oe9);
    wait_n(Q);
    sda_m = 1'b0;
    wait_n(Q);
    scl_m = 1'b1;
    wait_n(1);
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    wait_n(1);
    check("rstmid_oe", {31'h0, bus.sda_oe}, 32'h0);
    check("rstmid_busy", {31'h0, busy}, 32'h0);
    wait_n(2 * Q - 3);
    scl_m = 1'b0;
    for (int i = 3; i >= 0; i--) clk_bit(1'b1, a2, oe9);
    clk_bit(1'b1, a2, oe9);
    check("rstmid_no_ack", {31'h0, ~a2}, 32'h0);
    send_stop();
    wait_n(4);
    check("rstmid_strobes", strobe_cnt - s0, 32'h0);
    dbg_check("rstmid_reg30", 8'h30, 8'h00);

    s0 = strobe_cnt;
    send_start();
    write_byte(8'h42, a0);
    write_byte(8'h30, a1);
    write_byte(8'h5A, a2);
    send_stop();
    wait_n(4);
    check("post_rst_ack", {29'h0, a0, a1, a2}, 32'h7);
    check("post_rst_strobes", strobe_cnt - s0, 32'h1);
    dbg_check("post_rst_reg30", 8'h30, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
